// File: rtl/code_conv_pipe.sv
// Two-stage pipelined binary/Gray converter with valid/ready on both sides.
// Each word carries its own direction bit; S1 captures, S2 holds the converted word.
module code_conv_pipe #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_mode_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_mode_o,
  output logic [CNT_W-1:0] xfer_cnt_o
);

  logic             s1_valid_q, s1_valid_d;
  logic             s1_mode_q, s1_mode_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic             s2_valid_q, s2_valid_d;
  logic             s2_mode_q, s2_mode_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic             stall;

  // mode 0: binary->Gray; mode 1: Gray->binary as a prefix XOR from the MSB down
  function automatic logic [WIDTH-1:0] convert(input logic mode, input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    r = '0;
    r[WIDTH-1] = w[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      r[i] = mode ? (r[i+1] ^ w[i]) : (w[i+1] ^ w[i]);
    end
    return r;
  endfunction

  always_comb begin
    stall      = s2_valid_q && !out_ready_i;
    in_ready_o = !s1_valid_q || !stall;

    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_mode_d  = s2_mode_q;
    s2_data_d  = s2_data_q;
    xfer_cnt_d = xfer_cnt_q;

    // Payload only loads on a real input word so idle-bus X never enters the pipe
    if (in_ready_o) begin
      s1_valid_d = in_valid_i;
      if (in_valid_i) begin
        s1_mode_d = in_mode_i;
        s1_data_d = in_data_i;
      end
    end

    if (!stall) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_mode_d = s1_mode_q;
        s2_data_d = convert(s1_mode_q, s1_data_q);
      end
    end

    if (s2_valid_q && out_ready_i) begin
      xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_mode_q  <= 1'b0;
      s2_data_q  <= '0;
      xfer_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_mode_q  <= s2_mode_d;
      s2_data_q  <= s2_data_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign out_data_o  = s2_data_q;
  assign out_mode_o  = s2_mode_q;
  assign xfer_cnt_o  = xfer_cnt_q;

endmodule
